// File: rtl/mipsalu_arbiter.sv
// mipsalu_arbiter: two-requester round-robin front end for the shared
// combinational MIPS ALU. One operation at a time flows IDLE -> EXEC -> RESP.
// The winning request is latched. The ALU is driven for one cycle and its
// result is registered. A tagged response is then held until the consumer
// accepts it.
module mipsalu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [5:0]        req0_funct,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [5:0]        req1_funct,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [3:0]        alu_ctl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CTL_ILLEGAL = 4'hF;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [3:0]        ctl_q, ctl_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              id_q, id_d;
    logic              illegal_q, illegal_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_err_q, rsp_err_d;

    logic              grant;
    logic              accept;
    logic [5:0]        sel_funct;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [3:0]        dec_ctl;
    logic              dec_illegal;

    // Round-robin choice among the valid requesters; ready only in IDLE and never in reset.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        accept     = (state_q == IDLE) && !reset && (req0_valid || req1_valid);
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
        sel_funct  = grant ? req1_funct : req0_funct;
        sel_a      = grant ? req1_a     : req0_a;
        sel_b      = grant ? req1_b     : req0_b;
    end

    // Map the granted requester's funct code to the ALU control code; anything unknown is illegal.
    always_comb begin
        dec_ctl     = CTL_ILLEGAL;
        dec_illegal = 1'b0;
        case (sel_funct)
            6'd32:   dec_ctl = 4'd2;
            6'd34:   dec_ctl = 4'd6;
            6'd36:   dec_ctl = 4'd0;
            6'd37:   dec_ctl = 4'd1;
            6'd39:   dec_ctl = 4'd12;
            6'd42:   dec_ctl = 4'd7;
            default: dec_illegal = 1'b1;
        endcase
    end

    // Next-state logic: latch the request on accept, capture the ALU in EXEC, hold the response in RESP.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ctl_d        = ctl_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        illegal_d    = illegal_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = EXEC;
                    last_grant_d = grant;
                    ctl_d        = dec_ctl;
                    a_d          = sel_a;
                    b_d          = sel_b;
                    id_d         = grant;
                    illegal_d    = dec_illegal;
                end
            end
            EXEC: begin
                state_d    = RESP;
                rsp_data_d = alu_out;
                // An illegal op never reports Zero, even though the ALU's default result is 0.
                rsp_zero_d = illegal_q ? 1'b0 : alu_zero;
                rsp_err_d  = illegal_q;
                rsp_id_d   = id_q;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and data registers with synchronous reset; an in-flight operation is simply dropped.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            ctl_q        <= CTL_ILLEGAL;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            illegal_q    <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ctl_q        <= ctl_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            illegal_q    <= illegal_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // ALU is driven only during EXEC; otherwise it sees the idle control code and zero operands.
    always_comb begin
        alu_ctl = CTL_ILLEGAL;
        alu_a   = '0;
        alu_b   = '0;
        if (state_q == EXEC) begin
            alu_ctl = ctl_q;
            alu_a   = a_q;
            alu_b   = b_q;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mipsalu_arbiter.sv
// Testbench for mipsalu_arbiter: a behavioural ALU drives alu_out/alu_zero.
// Expectations come from a funct-level result model and a round-robin grant model.
module tb_mipsalu_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [5:0]  req0_funct;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [5:0]  req1_funct;
    logic [31:0] req1_a, req1_b;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_a, alu_b, alu_out;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [31:0] rsp_data;

    int checks = 0;
    int errors = 0;
    logic model_last;

    typedef struct packed {
        logic        rdy0;
        logic        rdy1;
        logic        exec_valid;
        logic        busy_rdy;
        logic        rsp_valid;
        logic        rsp_id;
        logic        rsp_zero;
        logic        rsp_err;
        logic        stable;
        logic        after_valid;
        logic        nx0;
        logic        nx1;
        logic [3:0]  ctl;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] rsp_data;
    } obs_t;

    mipsalu_arbiter #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_funct(req0_funct),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_funct(req1_funct),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural MIPS ALU (SLT is unsigned, unknown control gives 0).
    always_comb begin
        case (alu_ctl)
            4'd0:    alu_out = alu_a & alu_b;
            4'd1:    alu_out = alu_a | alu_b;
            4'd2:    alu_out = alu_a + alu_b;
            4'd6:    alu_out = alu_a - alu_b;
            4'd7:    alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
            4'd12:   alu_out = ~(alu_a | alu_b);
            default: alu_out = 32'd0;
        endcase
    end
    assign alu_zero = (alu_out == 32'd0);

    // ---------------- reference model ----------------
    function automatic logic ref_legal(input logic [5:0] f);
        return (f == 6'd32) || (f == 6'd34) || (f == 6'd36) ||
               (f == 6'd37) || (f == 6'd39) || (f == 6'd42);
    endfunction

    function automatic logic [31:0] ref_result(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            6'd32:   return a + b;
            6'd34:   return a - b;
            6'd36:   return a & b;
            6'd37:   return a | b;
            6'd39:   return ~(a | b);
            6'd42:   return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] ref_ctl(input logic [5:0] f);
        case (f)
            6'd32:   return 4'd2;
            6'd34:   return 4'd6;
            6'd36:   return 4'd0;
            6'd37:   return 4'd1;
            6'd39:   return 4'd12;
            6'd42:   return 4'd7;
            default: return 4'hF;
        endcase
    endfunction

    // Round robin: a lone requester wins; on contention, whoever did not win last time.
    function automatic logic exp_grant(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return !last;
        return v1;
    endfunction

    function automatic logic [5:0] pick_funct();
        logic [5:0] tbl [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};
        int r = $urandom_range(0, 7);
        if (r < 6) return tbl[r];
        return 6'($urandom);
    endfunction

    // ---------------- stimulus ----------------
    task automatic drive_junk();
        req0_valid = 1'($urandom); req0_funct = 6'($urandom);
        req0_a = $urandom; req0_b = $urandom;
        req1_valid = 1'($urandom); req1_funct = 6'($urandom);
        req1_a = $urandom; req1_b = $urandom;
    endtask

    // Runs one operation from IDLE (called just after a rising edge) and records observations.
    task automatic do_op(input logic v0, input logic [5:0] f0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [5:0] f1, input logic [31:0] a1, input logic [31:0] b1,
                         input int hold, input bit keep, output obs_t o);
        o = '0;
        req0_valid = v0; req0_funct = f0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_funct = f1; req1_a = a1; req1_b = b1;
        rsp_ready  = (hold == 0);
        #1;
        o.rdy0 = req0_ready;
        o.rdy1 = req1_ready;
        @(posedge clk); #1;
        if (!keep) drive_junk();
        #1;
        o.ctl        = alu_ctl;
        o.ea         = alu_a;
        o.eb         = alu_b;
        o.exec_valid = rsp_valid;
        o.busy_rdy   = req0_ready | req1_ready;
        @(posedge clk); #1;
        if (!keep) drive_junk();
        #1;
        o.busy_rdy  = o.busy_rdy | req0_ready | req1_ready;
        o.rsp_valid = rsp_valid;
        o.rsp_id    = rsp_id;
        o.rsp_data  = rsp_data;
        o.rsp_zero  = rsp_zero;
        o.rsp_err   = rsp_err;
        o.stable    = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!keep) drive_junk();
            #1;
            o.busy_rdy = o.busy_rdy | req0_ready | req1_ready;
            if (rsp_valid !== 1'b1 || rsp_id !== o.rsp_id || rsp_data !== o.rsp_data ||
                rsp_zero !== o.rsp_zero || rsp_err !== o.rsp_err)
                o.stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        if (!keep) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        #1;
        o.after_valid = rsp_valid;
        o.nx0 = req0_ready;
        o.nx1 = req1_ready;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 1'b1; req0_funct = 6'd32; req0_a = 32'd1; req0_b = 32'd2;
        req1_valid = 1'b1; req1_funct = 6'd34; req1_a = 32'd3; req1_b = 32'd4;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy0: got %b expected 0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy1: got %b expected 0", req1_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %b expected 0", rsp_id); end
        checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        checks++; if (rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_zero_err: got %b%b expected 00", rsp_zero, rsp_err); end
        checks++; if (alu_ctl !== 4'hF) begin errors++; $display("FAIL reset_alu_ctl: got %h expected f", alu_ctl); end
        checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin errors++; $display("FAIL reset_alu_ab: got %h/%h expected 0/0", alu_a, alu_b); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b0;
        model_last = 1'b1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_no_op: got rsp_valid %b expected 0", rsp_valid); end
    endtask

    task automatic test_single();
        obs_t o;
        do_op(1'b1, 6'd32, 32'd5, 32'd7, 1'b0, 6'd0, 32'd0, 32'd0, 0, 1'b0, o);
        model_last = 1'b0;
        checks++; if (o.rdy0 !== 1'b1 || o.rdy1 !== 1'b0) begin errors++; $display("FAIL single_ready: got %b%b expected 10", o.rdy0, o.rdy1); end
        checks++; if (o.ctl !== 4'd2) begin errors++; $display("FAIL single_alu_ctl: got %h expected 2", o.ctl); end
        checks++; if (o.ea !== 32'd5 || o.eb !== 32'd7) begin errors++; $display("FAIL single_alu_ab: got %h/%h expected 5/7", o.ea, o.eb); end
        checks++; if (o.exec_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", o.exec_valid); end
        checks++; if (o.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b expected 1", o.rsp_valid); end
        checks++; if (o.rsp_data !== 32'd12) begin errors++; $display("FAIL single_data: got %h expected c", o.rsp_data); end
        checks++; if (o.rsp_zero !== 1'b0 || o.rsp_err !== 1'b0 || o.rsp_id !== 1'b0) begin
            errors++; $display("FAIL single_flags: got zero=%b err=%b id=%b expected 0 0 0", o.rsp_zero, o.rsp_err, o.rsp_id); end
        checks++; if (o.busy_rdy !== 1'b0) begin errors++; $display("FAIL single_busy_ready: got %b expected 0", o.busy_rdy); end
        checks++; if (o.after_valid !== 1'b0) begin errors++; $display("FAIL single_release: got rsp_valid %b expected 0", o.after_valid); end
    endtask

    task automatic test_functs();
        logic [5:0]  tf [8] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd34, 6'd42};
        logic [31:0] ta [8] = '{32'hC, 32'hC, 32'hC, 32'hC, 32'hC, 32'hC, 32'd3, 32'd1};
        logic [31:0] tb [8] = '{32'hA, 32'hA, 32'hA, 32'hA, 32'hA, 32'hA, 32'd3, 32'hFFFFFFFF};
        logic [31:0] td [8] = '{32'h16, 32'h2, 32'h8, 32'hE, 32'hFFFFFFF1, 32'h0, 32'h0, 32'h1};
        obs_t o;
        for (int i = 0; i < 8; i++) begin
            do_op(1'b0, 6'd0, 32'd0, 32'd0, 1'b1, tf[i], ta[i], tb[i], 0, 1'b0, o);
            model_last = 1'b1;
            checks++; if (o.rdy1 !== 1'b1 || o.rdy0 !== 1'b0) begin errors++; $display("FAIL funct%0d_ready: got %b%b expected 01", i, o.rdy0, o.rdy1); end
            checks++; if (o.ctl !== ref_ctl(tf[i])) begin errors++; $display("FAIL funct%0d_alu_ctl: got %h expected %h", i, o.ctl, ref_ctl(tf[i])); end
            checks++; if (o.rsp_data !== td[i]) begin errors++; $display("FAIL funct%0d_data: got %h expected %h", i, o.rsp_data, td[i]); end
            checks++; if (o.rsp_zero !== (td[i] == 32'd0)) begin errors++; $display("FAIL funct%0d_zero: got %b expected %b", i, o.rsp_zero, td[i] == 32'd0); end
            checks++; if (o.rsp_id !== 1'b1 || o.rsp_err !== 1'b0) begin errors++; $display("FAIL funct%0d_id_err: got %b/%b expected 1/0", i, o.rsp_id, o.rsp_err); end
        end
    endtask

    task automatic test_contention();
        obs_t o;
        logic g;
        for (int k = 0; k < 4; k++) begin
            g = exp_grant(1'b1, 1'b1, model_last);
            do_op(1'b1, 6'd32, 32'(k), 32'(k + 1), 1'b1, 6'd34, 32'(10 * k + 9), 32'(k), 0, 1'b1, o);
            model_last = g;
            checks++; if (o.rdy0 !== !g || o.rdy1 !== g) begin errors++; $display("FAIL contend%0d_ready: got %b%b expected %b%b", k, o.rdy0, o.rdy1, !g, g); end
            checks++; if (o.rsp_id !== g || g !== 1'(k % 2)) begin errors++; $display("FAIL contend%0d_id: got %b expected %0d", k, o.rsp_id, k % 2); end
            checks++; if (o.rsp_data !== (g ? ref_result(6'd34, 32'(10 * k + 9), 32'(k)) : ref_result(6'd32, 32'(k), 32'(k + 1)))) begin
                errors++; $display("FAIL contend%0d_data: got %h", k, o.rsp_data); end
            checks++; if (o.busy_rdy !== 1'b0) begin errors++; $display("FAIL contend%0d_busy_ready: got %b expected 0", k, o.busy_rdy); end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        obs_t o;
        logic g;
        g = exp_grant(1'b1, 1'b1, model_last);
        do_op(1'b1, 6'd36, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1, 6'd37, 32'h1, 32'h2, 5, 1'b1, o);
        model_last = g;
        checks++; if (o.rsp_valid !== 1'b1 || o.stable !== 1'b1) begin errors++; $display("FAIL bp_stable: got valid=%b stable=%b expected 1 1", o.rsp_valid, o.stable); end
        checks++; if (o.busy_rdy !== 1'b0) begin errors++; $display("FAIL bp_ready_held: got %b expected 0", o.busy_rdy); end
        checks++; if (o.rsp_data !== (g ? 32'h3 : 32'h00F0_1200)) begin errors++; $display("FAIL bp_data: got %h", o.rsp_data); end
        checks++; if (o.after_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got rsp_valid %b expected 0", o.after_valid); end
        checks++; if (o.nx0 !== g || o.nx1 !== !g) begin errors++; $display("FAIL bp_next_grant: got %b%b expected %b%b", o.nx0, o.nx1, g, !g); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_illegal();
        obs_t o;
        logic [31:0] x;
        do_op(1'b1, 6'd0, 32'd0, 32'd0, 1'b0, 6'd0, 32'd0, 32'd0, 0, 1'b0, o);
        model_last = 1'b0;
        checks++; if (o.ctl !== 4'hF) begin errors++; $display("FAIL illegal_alu_ctl: got %h expected f", o.ctl); end
        checks++; if (o.rsp_valid !== 1'b1 || o.rsp_err !== 1'b1) begin errors++; $display("FAIL illegal_err: got valid=%b err=%b expected 1 1", o.rsp_valid, o.rsp_err); end
        checks++; if (o.rsp_data !== 32'd0 || o.rsp_zero !== 1'b0) begin errors++; $display("FAIL illegal_data_zero: got %h/%b expected 0/0", o.rsp_data, o.rsp_zero); end
        x = $urandom | 32'h1;
        do_op(1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 6'd43, x, x, 1, 1'b0, o);
        model_last = 1'b1;
        checks++; if (o.rsp_err !== 1'b1 || o.rsp_zero !== 1'b0 || o.rsp_id !== 1'b1) begin
            errors++; $display("FAIL illegal43_flags: got err=%b zero=%b id=%b expected 1 0 1", o.rsp_err, o.rsp_zero, o.rsp_id); end
        checks++; if (o.rsp_data !== 32'd0) begin errors++; $display("FAIL illegal43_data: got %h expected 0", o.rsp_data); end
    endtask

    task automatic test_reset_mid_op();
        obs_t o;
        req0_valid = 1'b1; req0_funct = 6'd32; req0_a = 32'd9; req0_b = 32'd9;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || req0_ready !== 1'b0) begin errors++; $display("FAIL midrst_valid: got valid=%b rdy0=%b expected 0 0", rsp_valid, req0_ready); end
        checks++; if (rsp_data !== 32'd0 || rsp_id !== 1'b0 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL midrst_rsp: got data=%h id=%b zero=%b err=%b expected all 0", rsp_data, rsp_id, rsp_zero, rsp_err); end
        checks++; if (alu_ctl !== 4'hF || alu_a !== 32'd0) begin errors++; $display("FAIL midrst_alu: got ctl=%h a=%h expected f 0", alu_ctl, alu_a); end
        reset = 1'b0;
        model_last = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale%0d: got rsp_valid %b expected 0", i, rsp_valid); end
        end
        do_op(1'b1, 6'd34, 32'd20, 32'd6, 1'b1, 6'd32, 32'd1, 32'd1, 0, 1'b0, o);
        model_last = 1'b0;
        checks++; if (o.rdy0 !== 1'b1 || o.rdy1 !== 1'b0) begin errors++; $display("FAIL midrst_first_grant: got %b%b expected 10", o.rdy0, o.rdy1); end
        checks++; if (o.rsp_id !== 1'b0 || o.rsp_data !== 32'd14) begin errors++; $display("FAIL midrst_new_op: got id=%b data=%h expected 0 e", o.rsp_id, o.rsp_data); end
    endtask

    task automatic test_random();
        obs_t o;
        logic v0, v1, g, legal;
        logic [5:0] f0, f1, ef;
        logic [31:0] a0, b0, a1, b1, ea, eb, ed;
        int hold;
        bit keep;
        for (int n = 0; n < 40; n++) begin
            v0 = 1'($urandom); v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            f0 = pick_funct(); f1 = pick_funct();
            a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            a1 = $urandom; b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            hold = $urandom_range(0, 3);
            keep = 1'($urandom);
            g = exp_grant(v0, v1, model_last);
            do_op(v0, f0, a0, b0, v1, f1, a1, b1, hold, keep, o);
            model_last = g;
            ef = g ? f1 : f0; ea = g ? a1 : a0; eb = g ? b1 : b0;
            ed = ref_result(ef, ea, eb);
            legal = ref_legal(ef);
            checks++; if (o.rdy0 !== !g || o.rdy1 !== g) begin errors++; $display("FAIL rand%0d_ready: got %b%b expected %b%b", n, o.rdy0, o.rdy1, !g, g); end
            checks++; if (o.rsp_valid !== 1'b1 || o.rsp_id !== g) begin errors++; $display("FAIL rand%0d_id: got valid=%b id=%b expected 1 %b", n, o.rsp_valid, o.rsp_id, g); end
            checks++; if (o.rsp_data !== ed) begin errors++; $display("FAIL rand%0d_data: funct=%0d got %h expected %h", n, ef, o.rsp_data, ed); end
            checks++; if (o.rsp_zero !== (legal && ed == 32'd0) || o.rsp_err !== !legal) begin
                errors++; $display("FAIL rand%0d_flags: got zero=%b err=%b expected %b %b", n, o.rsp_zero, o.rsp_err, legal && ed == 32'd0, !legal); end
            checks++; if (o.busy_rdy !== 1'b0 || o.stable !== 1'b1 || o.after_valid !== 1'b0) begin
                errors++; $display("FAIL rand%0d_handshake: got busy=%b stable=%b after=%b expected 0 1 0", n, o.busy_rdy, o.stable, o.after_valid); end
            if (keep) begin
                checks++; if (o.nx0 !== (!exp_grant(v0, v1, model_last)) || o.nx1 !== exp_grant(v0, v1, model_last)) begin
                    errors++; $display("FAIL rand%0d_next_grant: got %b%b", n, o.nx0, o.nx1); end
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_funct = 6'd0; req0_a = 32'd0; req0_b = 32'd0;
        req1_valid = 1'b0; req1_funct = 6'd0; req1_a = 32'd0; req1_b = 32'd0;
        rsp_ready = 1'b0;
        model_last = 1'b1;
        test_reset();
        test_single();
        test_functs();
        test_contention();
        test_backpressure();
        test_illegal();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mipsalu_arbiter.md
# mipsalu_arbiter

Two-requester arbiter and sequencer for the shared combinational MIPSALU. Each requester presents an R-type funct code and two operands over a valid/ready handshake. The block grants one requester per operation (round-robin), decodes funct to ALUCtl, drives the ALU for one cycle, registers ALUOut/Zero, and returns a tagged response over a valid/ready handshake. It sits between the decode stage and the single ALU instance in the datapath.

## Interface
- DATA_W, 32, operand/result width; must match the ALU width.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 granted this cycle; a transfer occurs when req0_valid && req0_ready.
- req0_funct  in  6  MIPS funct code.
- req0_a, req0_b  in  DATA_W  operands.
- req1_valid, req1_ready, req1_funct, req1_a, req1_b: same as requester 0, for requester 1.
- alu_ctl  out  4  to ALU ALUCtl.
- alu_a, alu_b  out  DATA_W  to ALU A, B.
- alu_out  in  DATA_W  from ALU ALUOut (combinational).
- alu_zero  in  1  from ALU Zero.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester index that issued the operation.
- rsp_data  out  DATA_W  registered ALU result.
- rsp_zero  out  1  registered Zero flag.
- rsp_err  out  1  funct code was illegal.

## Operation
- States: IDLE, EXEC, RESP. Reset enters IDLE.
- Funct decode: 32→2 (add), 34→6 (sub), 36→0 (and), 37→1 (or), 39→12 (nor), 42→7 (slt). Any other value is illegal and uses ctl 4'hF.
- Arbitration happens only in IDLE.
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted last is granted.
  - last_grant resets to 1, so requester 0 wins the first contention.
- reqN_ready = (state==IDLE) && grant==N. Ready depends combinationally on both valids. Both readies are never high together.
- IDLE → EXEC on a transfer. That cycle latches funct-decoded ctl, a, b, id, and an illegal flag, and updates last_grant.
- EXEC lasts exactly one cycle: alu_ctl/alu_a/alu_b are driven from the registers. At the end of EXEC, rsp_data←alu_out, rsp_zero←(illegal ? 0 : alu_zero), rsp_err←illegal, rsp_id←id. Then go to RESP.
- RESP holds rsp_valid=1 with stable rsp_* until rsp_ready=1, then goes to IDLE.
- Outside EXEC: alu_ctl=4'hF, alu_a=alu_b=0.
- The ALU SLT is an unsigned compare. The arbiter does not alter operands or results.
- Reset values: state IDLE, req0_ready=req1_ready=0 during reset, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0, rsp_err=0, alu_ctl=4'hF, alu_a=alu_b=0, last_grant=1.

## Timing
- Cycle T (IDLE): transfer. T+1: EXEC, ALU driven. T+2: rsp_valid=1.
- Minimum 3 cycles per operation: if rsp_ready=1 at T+2, IDLE at T+3 and the next accept is at T+3.
- Back-pressure: rsp_ready=0 holds RESP indefinitely. No requests are accepted meanwhile (both readies 0).
- Fairness: under continuous contention, grants alternate 0,1,0,1…; each requester waits at most one operation.
- Request changes while not ready are ignored. Operands are sampled only on the transfer cycle.
- Reset asserted in EXEC or RESP discards the operation: the next cycle shows IDLE, rsp_valid=0, all reset values, and no response is ever produced for it.
- Reset and a valid request in the same cycle: no transfer (ready forced 0).
- Illegal funct still takes the full 3-cycle path. rsp_data=0 (ALU default), rsp_zero=0, rsp_err=1.

## Test plan
- Single op: req0 funct=32, a=5, b=7 → req0_ready at T, alu_ctl=2 at T+1, rsp_valid at T+2 with rsp_data=12, rsp_zero=0, rsp_id=0, rsp_err=0.
- All functs on req1 with a=32'hC, b=32'hA: 34→2, 36→8, 37→14, 39→32'hFFFFFFF1, 42→0. Then sub a=b=3 → rsp_data=0, rsp_zero=1. Then slt a=1, b=32'hFFFFFFFF → 1.
- Contention: both valid continuously for 4 ops → rsp_id sequence 0,1,0,1, one response every 3 cycles with rsp_ready=1.
- Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_* stable, both readies 0. Release → IDLE next cycle, then the next grant.
- Illegal funct=0 with a=b=0 → rsp_err=1, rsp_data=0, rsp_zero=0.
- Reset mid-op: assert reset during EXEC → rsp_valid stays 0, all outputs at reset values. After release, contention grants requester 0 first.
